multicycle_control: RTL and testbench

Main control FSM for the multicycle CPU datapath. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives all datapath mux selects and write enables. It supplies alu_op to the ALU control decoder: 00 add, 01 subtract/compare, 10 R-type funct decode. Memory accesses use a request/ready handshake, so slow memory inserts wait states.

---
 rtl/multicycle_control_pkg.sv | 61 ++++++
 rtl/multicycle_control.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_pkg
//  Purpose  : Shared encodings for the multicycle CPU control path: FSM state
//             codes, instruction opcodes, alu_op codes and the datapath mux
//             select codes used by the control FSM, the datapath and the ALU
//             control decoder.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package multicycle_control_pkg;

  // FSM state encoding; the numeric values are visible on the debug port.
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_RWB     = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_ADDI_EX = 4'd11,
    S_ADDI_WB = 4'd12
  } state_t;

  // Instruction opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // alu_op codes to the ALU control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // alu_src_b selects
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // pc_source selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // True for every opcode the FSM knows how to sequence.
  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control
//  Purpose  : Main control FSM of the multicycle CPU. Steps each instruction
//             through fetch / decode / execute / memory / writeback and drives
//             the datapath mux selects and write enables. Memory accesses use
//             a request/ready handshake so slow memory inserts wait states.
//  Ports    :
//    clk           in   rising-edge clock
//    reset         in   synchronous active-high reset
//    run           in   start fetching from IDLE / continue after retirement
//    opcode[5:0]   in   instruction[31:26] from the instruction register
//    mem_ready     in   memory finished the current access this cycle
//    pc_write      out  unconditional PC load
//    pc_write_cond out  PC load if ALU zero (beq)
//    i_or_d        out  memory address select (0 PC, 1 ALUOut)
//    mem_read      out  memory read request
//    mem_write     out  memory write request
//    ir_write      out  instruction register load
//    mem_to_reg    out  register write data (0 ALUOut, 1 MDR)
//    reg_dst       out  destination register (0 rt, 1 rd)
//    reg_write     out  register file write enable
//    alu_src_a     out  ALU A select (0 PC, 1 reg A)
//    alu_src_b     out  ALU B select (B / 4 / imm / imm<<2)
//    alu_op[1:0]   out  to ALU control decoder
//    pc_source     out  PC source (ALU / ALUOut / jump target)
//    illegal_op    out  one-cycle pulse on an unrecognised opcode
//    instr_done    out  one-cycle pulse when an instruction retires
//    state[3:0]    out  current state, for debug
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       instr_done,
  output logic [3:0] state
);

  state_t r_state;
  state_t w_next_state;

  // State after an instruction retires: keep going unless run was dropped.
  state_t w_retire_state;
  assign w_retire_state = run ? S_FETCH : S_IDLE;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE:    w_next_state = run ? S_FETCH : S_IDLE;
      S_FETCH:   w_next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_EXEC;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_J:         w_next_state = S_JUMP;
          OP_ADDI:      w_next_state = S_ADDI_EX;
          default:      w_next_state = S_FETCH;  // illegal: skip and refetch
        endcase
      end
      // Only LW and SW reach MEMADR, so anything that is not LW is SW.
      S_MEMADR:  w_next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   w_next_state = w_retire_state;
      S_MEMWR:   w_next_state = mem_ready ? w_retire_state : S_MEMWR;
      S_EXEC:    w_next_state = S_RWB;
      S_RWB:     w_next_state = w_retire_state;
      S_BRANCH:  w_next_state = w_retire_state;
      S_JUMP:    w_next_state = w_retire_state;
      S_ADDI_EX: w_next_state = S_ADDI_WB;
      S_ADDI_WB: w_next_state = w_retire_state;
      default:   w_next_state = S_IDLE;           // codes 13-15 recover
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode. Moore on the state register except for the handshake
  // qualified strobes (FETCH pc/ir load, MEMWR retire) and the DECODE
  // illegal-opcode pulse. Everything is forced low while reset is asserted so
  // an aborted access does not leave a request on the bus.
  // --------------------------------------------------------------------------
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    illegal_op    = 1'b0;
    instr_done    = 1'b0;
    state         = 4'd0;
    if (!reset) begin
      state = r_state;
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          pc_write  = mem_ready;
          ir_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b  = SRCB_IMM_SH;   // branch target precompute
          illegal_op = ~is_legal_op(opcode);
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_FUNCT;
        end
        S_RWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALUOP_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
          instr_done    = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = PCSRC_JUMP;
          instr_done = 1'b1;
        end
        S_ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_ADDI_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_control
//  Purpose  : Scoreboard bench for multicycle_control. The stimulus process
//             drives one cycle of inputs and queues the expected output vector
//             for that cycle; a monitor pops and compares on each falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b1;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, instr_done;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .instr_done(instr_done),
    .state(state)
  );

  always #5 clk = ~clk;

  // {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
  //  illegal_op, instr_done}
  logic [21:0] got;
  assign got = {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                alu_op, pc_source, illegal_op, instr_done};

  typedef struct {
    logic [21:0] v;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   step_no = 0;

  // Expected outputs for a given state, taken straight from the per-state
  // output list of the control table.
  function automatic logic [21:0] ex(bit rst, int st, bit rdy, logic [5:0] op);
    logic [3:0] s;
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, ill, dn;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, ill, dn} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    s = st[3:0];
    if (rst) return 22'd0;
    case (st)
      1:  begin mr = 1; asb = 2'b01; pw = rdy; irw = rdy; end
      2:  begin asb = 2'b11;
                ill = !(op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
                        op == 6'b000100 || op == 6'b000010 || op == 6'b001000); end
      3:  begin asa = 1; asb = 2'b10; end
      4:  begin mr = 1; iod = 1; end
      5:  begin rw = 1; m2r = 1; dn = 1; end
      6:  begin mw = 1; iod = 1; dn = rdy; end
      7:  begin asa = 1; aop = 2'b10; end
      8:  begin rw = 1; rd = 1; dn = 1; end
      9:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; dn = 1; end
      10: begin pw = 1; psrc = 2'b10; dn = 1; end
      11: begin asa = 1; asb = 2'b10; end
      12: begin rw = 1; dn = 1; end
      default: ;
    endcase
    return {s, pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, ill, dn};
  endfunction

  task automatic push(input logic [21:0] v, input string name);
    exp_t e;
    e.v   = v;
    e.tag = $sformatf("%s#%0d", name, step_no);
    exp_q.push_back(e);
    step_no++;
  endtask

  // One clock cycle: drive inputs just after the edge and queue the outputs
  // expected while the FSM sits in state st.
  task automatic cyc(input bit rst, input bit rn, input logic [5:0] op,
                     input bit rdy, input int st, input string name);
    @(posedge clk);
    #1;
    reset = rst; run = rn; opcode = op; mem_ready = rdy;
    push(ex(rst, st, rdy, op), name);
  endtask

  // Monitor: compare one queued expectation per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e.v) begin
          n_err++;
          $display("FAIL %s: got %b (state %0d) expected %b (state %0d)",
                   e.tag, got, got[21:18], e.v, e.v[21:18]);
        end
      end
    end
  end

  localparam logic [5:0] BAD = 6'b111111;

  initial begin
    // Power-up reset
    cyc(1, 0, OP_LW, 1, 0, "rst");
    cyc(1, 0, OP_LW, 1, 0, "rst");
    // Start an LW, abort it with reset while waiting in MEMRD
    cyc(0, 1, OP_LW, 1, 0, "idle");
    cyc(0, 1, OP_LW, 1, 1, "lw0");
    cyc(0, 1, OP_LW, 1, 2, "lw0");
    cyc(0, 1, OP_LW, 1, 3, "lw0");
    cyc(0, 1, OP_LW, 0, 4, "lw0");
    cyc(1, 1, OP_LW, 0, 4, "rst_mid");
    cyc(1, 1, OP_LW, 0, 0, "rst_mid");
    cyc(1, 1, OP_LW, 0, 0, "rst_mid");
    cyc(0, 1, OP_RTYPE, 1, 0, "post_rst");
    // R-type
    cyc(0, 1, OP_RTYPE, 1, 1, "rtype");
    cyc(0, 1, OP_RTYPE, 1, 2, "rtype");
    cyc(0, 1, OP_RTYPE, 1, 7, "rtype");
    cyc(0, 1, OP_RTYPE, 1, 8, "rtype");
    // LW: 2 wait states in FETCH, 3 in MEMRD
    cyc(0, 1, OP_LW, 0, 1, "lw");
    cyc(0, 1, OP_LW, 0, 1, "lw");
    cyc(0, 1, OP_LW, 1, 1, "lw");
    cyc(0, 1, OP_LW, 1, 2, "lw");
    cyc(0, 1, OP_LW, 1, 3, "lw");
    cyc(0, 1, OP_LW, 0, 4, "lw");
    cyc(0, 1, OP_LW, 0, 4, "lw");
    cyc(0, 1, OP_LW, 0, 4, "lw");
    cyc(0, 1, OP_LW, 1, 4, "lw");
    cyc(0, 1, OP_LW, 1, 5, "lw");
    // SW with one wait state in MEMWR
    cyc(0, 1, OP_SW, 1, 1, "sw");
    cyc(0, 1, OP_SW, 1, 2, "sw");
    cyc(0, 1, OP_SW, 1, 3, "sw");
    cyc(0, 1, OP_SW, 0, 6, "sw");
    cyc(0, 1, OP_SW, 1, 6, "sw");
    // BEQ
    cyc(0, 1, OP_BEQ, 1, 1, "beq");
    cyc(0, 1, OP_BEQ, 1, 2, "beq");
    cyc(0, 1, OP_BEQ, 1, 9, "beq");
    // J
    cyc(0, 1, OP_J, 1, 1, "j");
    cyc(0, 1, OP_J, 1, 2, "j");
    cyc(0, 1, OP_J, 1, 10, "j");
    // ADDI
    cyc(0, 1, OP_ADDI, 1, 1, "addi");
    cyc(0, 1, OP_ADDI, 1, 2, "addi");
    cyc(0, 1, OP_ADDI, 1, 11, "addi");
    cyc(0, 1, OP_ADDI, 1, 12, "addi");
    // Illegal opcode: pulse in DECODE, back to FETCH
    cyc(0, 1, BAD, 1, 1, "ill");
    cyc(0, 1, BAD, 1, 2, "ill");
    // R-type with run dropped during EXEC
    cyc(0, 1, OP_RTYPE, 1, 1, "stop");
    cyc(0, 1, OP_RTYPE, 1, 2, "stop");
    cyc(0, 0, OP_RTYPE, 1, 7, "stop");
    cyc(0, 0, OP_RTYPE, 1, 8, "stop");
    cyc(0, 0, OP_RTYPE, 1, 0, "stop");
    cyc(0, 1, OP_RTYPE, 1, 0, "resume");
    cyc(0, 1, OP_RTYPE, 1, 1, "resume");
    // Unreachable code 15 recovers to IDLE
    @(posedge clk);
    #1;
    dut.r_state = state_t'(4'd15);
    push({4'd15, 18'd0}, "unreach");
    cyc(0, 1, OP_RTYPE, 1, 0, "unreach");
    cyc(0, 1, OP_RTYPE, 1, 1, "unreach");

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
